// File: rtl/vm_multi.sv
// Vending controller: N products with per-product price and stock, a coin
// inventory, and a greedy exact-change payout emitted one coin per clock.
module vm_multi #(
    parameter int                      N_PROD     = 3,
    parameter int                      PROD_W     = 4,
    parameter int                      VAL_W      = 8,
    parameter int                      CNT_W      = 8,
    parameter logic [N_PROD*VAL_W-1:0] PRICES     = {8'd4, 8'd3, 8'd2},
    parameter int                      STOCK_INIT = 2,
    parameter int                      COIN_INIT  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              escolher,
    input  logic [PROD_W-1:0] produto_escolhido,
    input  logic              coin_valid,
    input  logic [1:0]        coin_type,
    input  logic              dar_troco,
    input  logic              cancelar,
    input  logic              restock,
    output logic [VAL_W-1:0]  credito,
    output logic [VAL_W-1:0]  carteira,
    output logic [PROD_W-1:0] produto_vendido,
    output logic              vend_valid,
    output logic              coin_out_valid,
    output logic [1:0]        coin_out_type,
    output logic              coin_rej,
    output logic              esgotado,
    output logic              sem_troco,
    output logic [2:0]        estado
);
    localparam int PW = (VAL_W > CNT_W) ? VAL_W : CNT_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INSERT = 3'd1,
        S_CHECK  = 3'd2,
        S_VEND   = 3'd3,
        S_CHANGE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [VAL_W-1:0]    credito_q, credito_d, carteira_q, carteira_d;
    logic [VAL_W-1:0]    price_q, price_d, troco_q, troco_d;
    logic [PROD_W-1:0]   prod_q, prod_d, vendido_q, vendido_d;
    logic                refund_q, refund_d;
    logic [CNT_W-1:0]    stock_q [N_PROD];
    logic [CNT_W-1:0]    stock_d [N_PROD];
    logic [CNT_W-1:0]    inv_q [3];
    logic [CNT_W-1:0]    inv_d [3];
    logic [PW-1:0]       plan_q [3];
    logic [PW-1:0]       plan_d [3];
    logic                vend_q, vend_d, cout_v_q, cout_v_d;
    logic [1:0]          cout_t_q, cout_t_d;
    logic                rej_q, rej_d, esg_q, esg_d, sem_q, sem_d;

    logic [VAL_W-1:0]    price_tab [N_PROD];
    logic                sel_ok;
    logic [VAL_W-1:0]    sel_price;
    logic [VAL_W:0]      coin_val, coin_sum;
    logic                inv_full, coin_ok;
    logic [PW-1:0]       troco_w, q4, r4, q2, r2;
    logic [PW-1:0]       n_calc [3];
    logic                feasible;

    for (genvar gi = 0; gi < N_PROD; gi++) begin : g_price
        assign price_tab[gi] = PRICES[gi*VAL_W +: VAL_W];
    end

    always_comb begin
        sel_ok    = 1'b0;
        sel_price = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (produto_escolhido == PROD_W'(i + 1) && stock_q[i] != '0) begin
                sel_ok    = 1'b1;
                sel_price = price_tab[i];
            end
        end
    end

    always_comb begin
        coin_val = '0;
        inv_full = 1'b1;
        case (coin_type)
            2'd0: begin coin_val = (VAL_W+1)'(1); inv_full = (inv_q[0] == '1); end
            2'd1: begin coin_val = (VAL_W+1)'(2); inv_full = (inv_q[1] == '1); end
            2'd2: begin coin_val = (VAL_W+1)'(4); inv_full = (inv_q[2] == '1); end
            default: ;
        endcase
        coin_sum = {1'b0, credito_q} + coin_val;
        coin_ok  = coin_valid && (coin_type != 2'd3) && !coin_sum[VAL_W] && !inv_full;
    end

    // Greedy change plan bounded by inventory; index 2/1/0 = 100c/50c/25c.
    always_comb begin
        troco_w   = PW'(troco_q);
        q4        = troco_w >> 2;
        n_calc[2] = (PW'(inv_q[2]) < q4) ? PW'(inv_q[2]) : q4;
        r4        = troco_w - (n_calc[2] << 2);
        q2        = r4 >> 1;
        n_calc[1] = (PW'(inv_q[1]) < q2) ? PW'(inv_q[1]) : q2;
        r2        = r4 - (n_calc[1] << 1);
        n_calc[0] = (PW'(inv_q[0]) < r2) ? PW'(inv_q[0]) : r2;
        feasible  = (r2 == n_calc[0]);
    end

    always_comb begin
        state_d    = state_q;
        credito_d  = credito_q;
        carteira_d = carteira_q;
        price_d    = price_q;
        troco_d    = troco_q;
        prod_d     = prod_q;
        vendido_d  = vendido_q;
        refund_d   = refund_q;
        for (int i = 0; i < N_PROD; i++) stock_d[i] = stock_q[i];
        for (int i = 0; i < 3; i++) begin
            inv_d[i]  = inv_q[i];
            plan_d[i] = plan_q[i];
        end
        vend_d   = 1'b0;
        cout_v_d = 1'b0;
        cout_t_d = cout_t_q;
        rej_d    = 1'b0;
        esg_d    = 1'b0;
        sem_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                rej_d = coin_valid;
                if (restock) begin
                    for (int i = 0; i < N_PROD; i++) stock_d[i] = CNT_W'(STOCK_INIT);
                end
                if (escolher) begin
                    if (sel_ok) begin
                        prod_d  = produto_escolhido;
                        price_d = sel_price;
                        state_d = S_INSERT;
                    end else begin
                        esg_d = 1'b1;
                    end
                end
            end
            S_INSERT: begin
                if (coin_ok) begin
                    credito_d = coin_sum[VAL_W-1:0];
                    case (coin_type)
                        2'd0: inv_d[0] = inv_q[0] + 1'b1;
                        2'd1: inv_d[1] = inv_q[1] + 1'b1;
                        2'd2: inv_d[2] = inv_q[2] + 1'b1;
                        default: ;
                    endcase
                end else begin
                    rej_d = coin_valid;
                    if (cancelar) begin
                        troco_d  = credito_q;
                        refund_d = 1'b1;
                        state_d  = S_CHECK;
                    end else if (dar_troco && credito_q >= price_q) begin
                        troco_d  = credito_q - price_q;
                        refund_d = 1'b0;
                        state_d  = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                rej_d = coin_valid;
                // A refund only returns coins that were inserted, so it always pays out.
                if (feasible || refund_q) begin
                    for (int i = 0; i < 3; i++) begin
                        inv_d[i]  = inv_q[i] - CNT_W'(n_calc[i]);
                        plan_d[i] = n_calc[i];
                    end
                    if (refund_q) begin
                        state_d = S_CHANGE;
                    end else begin
                        state_d    = S_VEND;
                        vend_d     = 1'b1;
                        vendido_d  = prod_q;
                        carteira_d = carteira_q + price_q;
                        for (int i = 0; i < N_PROD; i++) begin
                            if (prod_q == PROD_W'(i + 1)) stock_d[i] = stock_q[i] - 1'b1;
                        end
                    end
                end else begin
                    sem_d   = 1'b1;
                    state_d = S_INSERT;
                end
            end
            S_VEND: begin
                rej_d   = coin_valid;
                state_d = S_CHANGE;
            end
            S_CHANGE: begin
                rej_d = coin_valid;
                if (plan_q[0] == '0 && plan_q[1] == '0 && plan_q[2] == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Every cycle spent in CHANGE carries the next coin, largest first.
        if (state_d == S_CHANGE) begin
            credito_d = '0;
            if (plan_d[2] != '0) begin
                cout_v_d  = 1'b1;
                cout_t_d  = 2'd2;
                plan_d[2] = plan_d[2] - 1'b1;
            end else if (plan_d[1] != '0) begin
                cout_v_d  = 1'b1;
                cout_t_d  = 2'd1;
                plan_d[1] = plan_d[1] - 1'b1;
            end else if (plan_d[0] != '0) begin
                cout_v_d  = 1'b1;
                cout_t_d  = 2'd0;
                plan_d[0] = plan_d[0] - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            credito_q  <= '0;
            carteira_q <= '0;
            price_q    <= '0;
            troco_q    <= '0;
            prod_q     <= '0;
            vendido_q  <= '0;
            refund_q   <= 1'b0;
            for (int i = 0; i < N_PROD; i++) stock_q[i] <= CNT_W'(STOCK_INIT);
            for (int i = 0; i < 3; i++) begin
                inv_q[i]  <= CNT_W'(COIN_INIT);
                plan_q[i] <= '0;
            end
            vend_q   <= 1'b0;
            cout_v_q <= 1'b0;
            cout_t_q <= 2'd0;
            rej_q    <= 1'b0;
            esg_q    <= 1'b0;
            sem_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            credito_q  <= credito_d;
            carteira_q <= carteira_d;
            price_q    <= price_d;
            troco_q    <= troco_d;
            prod_q     <= prod_d;
            vendido_q  <= vendido_d;
            refund_q   <= refund_d;
            for (int i = 0; i < N_PROD; i++) stock_q[i] <= stock_d[i];
            for (int i = 0; i < 3; i++) begin
                inv_q[i]  <= inv_d[i];
                plan_q[i] <= plan_d[i];
            end
            vend_q   <= vend_d;
            cout_v_q <= cout_v_d;
            cout_t_q <= cout_t_d;
            rej_q    <= rej_d;
            esg_q    <= esg_d;
            sem_q    <= sem_d;
        end
    end

    assign credito         = credito_q;
    assign carteira        = carteira_q;
    assign produto_vendido = vendido_q;
    assign vend_valid      = vend_q;
    assign coin_out_valid  = cout_v_q;
    assign coin_out_type   = cout_t_q;
    assign coin_rej        = rej_q;
    assign esgotado        = esg_q;
    assign sem_troco       = sem_q;
    assign estado          = state_q;

endmodule
